// File: rtl/alu_ctrl_if.sv
// alu_ctrl_if: command channel from instruction decode to alu_ctrl.
//   cmd_valid/cmd_ready : valid/ready handshake, transfer on a clock edge with both high
//   cmd_op              : ALU opcode
//   cmd_rd/rs/rt        : destination, operand A, operand B register addresses
// Modports: master = decode side, slave = controller side.
interface alu_ctrl_if #(
  parameter int op_width   = 4,
  parameter int addr_width = 3
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [op_width-1:0]   cmd_op;
  logic [addr_width-1:0] cmd_rd;
  logic [addr_width-1:0] cmd_rs;
  logic [addr_width-1:0] cmd_rt;

  modport master (output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_rt, output cmd_ready);
endinterface

// File: rtl/alu_ctrl.sv
// alu_ctrl: three-state (IDLE/EXEC/WB) issue controller for the combinational ALU.
// Owns the architectural register file (R0 hardwired to zero) and the car/zero/taken/err flags.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   cmd                 : alu_ctrl_if.slave command channel
//   alu_op/alu_ra/alu_rb: registered ALU inputs, held until the next accept
//   alu_res/alu_car/alu_zero/alu_branch : ALU outputs, sampled in EXEC
//   done                : one-cycle completion pulse (high in WB)
//   car_q/zero_q/taken_q/err_q : architectural flags
//   dbg_addr/dbg_data   : combinational register-file read port
// Build option: define ALU_CTRL_ERR_EN to make ops 11-15 set the sticky err_q flag;
// otherwise they are silent NOPs and err_q is tied low.
module alu_ctrl #(
  parameter int reg_width  = 8,
  parameter int op_width   = 4,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_ctrl_if.slave             cmd,
  output logic [op_width-1:0]   alu_op,
  output logic [reg_width-1:0]  alu_ra,
  output logic [reg_width-1:0]  alu_rb,
  input  logic [reg_width-1:0]  alu_res,
  input  logic [reg_width-1:0]  alu_car,
  input  logic                  alu_zero,
  input  logic                  alu_branch,
  output logic                  done,
  output logic [reg_width-1:0]  car_q,
  output logic                  zero_q,
  output logic                  taken_q,
  output logic                  err_q,
  input  logic [addr_width-1:0] dbg_addr,
  output logic [reg_width-1:0]  dbg_data
);
  localparam int NREG = 1 << addr_width;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;
  state_t state, state_nxt;

  logic accept, capture, commit;
  logic [addr_width-1:0] rd_q;
  logic [reg_width-1:0]  res_h, car_h;
  logic                  zero_h, br_h;

  // Entry 0 is reset to zero and never written, so it always reads 0.
  logic [NREG-1:0][reg_width-1:0] regs;

  // Opcode class decode; alu_op holds the accepted opcode through WB.
  logic wr_en, car_en, br_en;
  always_comb begin
    wr_en  = 1'b0;
    car_en = 1'b0;
    br_en  = 1'b0;
    case (int'(alu_op))
      0, 1, 2, 3, 6:  wr_en = 1'b1;
      4, 5, 8, 9, 10: begin wr_en = 1'b1; car_en = 1'b1; end
      7:              br_en = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cmd.cmd_ready  = 1'b0;
    done           = 1'b0;
    accept         = 1'b0;
    capture        = 1'b0;
    commit         = 1'b0;
    case (state)
      IDLE: begin
        cmd.cmd_ready = 1'b1;
        if (cmd.cmd_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        commit    = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are read at accept; a WB write lands before the next accept can happen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op <= '0;
      alu_ra <= '0;
      alu_rb <= '0;
      rd_q   <= '0;
    end else if (accept) begin
      alu_op <= cmd.cmd_op;
      alu_ra <= regs[cmd.cmd_rs];
      alu_rb <= regs[cmd.cmd_rt];
      rd_q   <= cmd.cmd_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_h  <= '0;
      car_h  <= '0;
      zero_h <= 1'b0;
      br_h   <= 1'b0;
    end else if (capture) begin
      res_h  <= alu_res;
      car_h  <= alu_car;
      zero_h <= alu_zero;
      br_h   <= alu_branch;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs    <= '0;
      car_q   <= '0;
      zero_q  <= 1'b0;
      taken_q <= 1'b0;
    end else if (commit) begin
      if (wr_en) begin
        if (rd_q != '0) regs[rd_q] <= res_h;
        zero_q <= zero_h;
      end
      // ALU leaves car_out stale for the other ops, so only these update car_q.
      if (car_en) car_q   <= car_h;
      if (br_en)  taken_q <= br_h;
    end
  end

`ifdef ALU_CTRL_ERR_EN
  logic ill_op;
  assign ill_op = (int'(alu_op) > 10);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               err_q <= 1'b0;
    else if (commit && ill_op) err_q <= 1'b1;
  end
`else
  assign err_q = 1'b0;
`endif

  assign dbg_data = regs[dbg_addr];
endmodule

// File: tb/tb_alu_ctrl.sv
// tb_alu_ctrl: directed + randomized bench for alu_ctrl. Contains a stand-in ALU, a
// transaction-level reference model and a per-cycle compare process.
module tb_alu_ctrl;
  localparam int RW = 8;
  localparam int OW = 4;
  localparam int AW = 3;
`ifdef ALU_CTRL_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  alu_ctrl_if #(.op_width(OW), .addr_width(AW)) cif();

  logic [OW-1:0] alu_op;
  logic [RW-1:0] alu_ra, alu_rb, alu_res, alu_car;
  logic          alu_zero, alu_branch;
  logic          done;
  logic [RW-1:0] car_q;
  logic          zero_q, taken_q, err_q;
  logic [AW-1:0] dbg_addr = '0;
  logic [RW-1:0] dbg_data;

  alu_ctrl #(.reg_width(RW), .op_width(OW), .addr_width(AW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cif),
    .alu_op(alu_op), .alu_ra(alu_ra), .alu_rb(alu_rb),
    .alu_res(alu_res), .alu_car(alu_car), .alu_zero(alu_zero), .alu_branch(alu_branch),
    .done(done), .car_q(car_q), .zero_q(zero_q), .taken_q(taken_q), .err_q(err_q),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Stand-in ALU. seed feeds op 6 (load), junk is the stale car_out / undefined-op garbage.
  logic [7:0] seed = '0;
  logic [7:0] junk = '0;

  typedef struct packed {
    logic       br;
    logic       z;
    logic [7:0] car;
    logic [7:0] res;
  } alu_out_t;

  function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [7:0] a, b, s, j);
    alu_out_t o;
    logic [15:0] w;
    o = '0;
    o.car = j;
    w = '0;
    case (op)
      4'd0:  o.res = a & b;
      4'd1:  o.res = a | b;
      4'd2:  o.res = a ^ b;
      4'd3:  o.res = ~(a | b);
      4'd4:  begin w = {8'h00, a} + {8'h00, b}; o.res = w[7:0]; o.car = w[15:8]; end
      4'd5:  begin o.res = a - b; o.car = {7'h00, (a < b)}; end
      4'd6:  o.res = s;
      4'd7:  begin o.res = a ^ b; o.br = (a == b); end
      4'd8:  begin w = {8'h00, a} << b[2:0]; o.res = w[7:0]; o.car = w[15:8]; end
      4'd9:  begin w = {a, 8'h00} >> b[2:0]; o.res = w[15:8]; o.car = w[7:0]; end
      4'd10: begin w = {8'h00, a} * {8'h00, b}; o.res = w[7:0]; o.car = w[15:8]; end
      default: o.res = j ^ 8'h5A;
    endcase
    o.z = (o.res == 8'h00);
    return o;
  endfunction

  alu_out_t alu_now;
  always_comb alu_now = alu_fn(alu_op, alu_ra, alu_rb, seed, junk);
  assign alu_res    = alu_now.res;
  assign alu_car    = alu_now.car;
  assign alu_zero   = alu_now.z;
  assign alu_branch = alu_now.br;

  // Reference model: a command is taken whenever the controller is free; the ALU answer is
  // sampled one edge later and committed on the edge after that.
  logic [7:0] m_r [8];
  logic [7:0] m_car;
  logic       m_zero, m_taken, m_err;
  int         m_busy;
  logic [3:0] m_op;
  logic [2:0] m_rd;
  logic [7:0] m_a, m_b;
  alu_out_t   m_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_r[i]) m_r[i] = 8'h00;
      m_car = 8'h00; m_zero = 1'b0; m_taken = 1'b0; m_err = 1'b0;
      m_busy = 0; m_op = '0; m_rd = '0; m_a = '0; m_b = '0; m_hold = '0;
    end else if (m_busy == 0) begin
      if (cif.cmd_valid) begin
        m_op = cif.cmd_op;
        m_rd = cif.cmd_rd;
        m_a  = m_r[cif.cmd_rs];
        m_b  = m_r[cif.cmd_rt];
        m_busy = 2;
      end
    end else if (m_busy == 2) begin
      m_hold = alu_fn(m_op, m_a, m_b, seed, junk);
      m_busy = 1;
    end else begin
      if (m_op <= 4'd10 && m_op != 4'd7) begin
        if (m_rd != 3'd0) m_r[m_rd] = m_hold.res;
        m_zero = m_hold.z;
      end
      if (m_op inside {4'd4, 4'd5, 4'd8, 4'd9, 4'd10}) m_car = m_hold.car;
      if (m_op == 4'd7) m_taken = m_hold.br;
      if (m_op >= 4'd11 && ERR_EN) m_err = 1'b1;
      m_busy = 0;
    end
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare; dbg_addr sweeps all registers.
  always @(negedge clk) begin
    cyc++;
    dbg_addr = cyc[2:0];
    #1;
    chk("cmd_ready", cif.cmd_ready, (m_busy == 0));
    chk("done",      done,          (m_busy == 1));
    chk("car_q",     car_q,         m_car);
    chk("zero_q",    zero_q,        m_zero);
    chk("taken_q",   taken_q,       m_taken);
    chk("err_q",     err_q,         m_err);
    chk("alu_op",    alu_op,        m_op);
    chk("alu_ra",    alu_ra,        m_a);
    chk("alu_rb",    alu_rb,        m_b);
    chk("dbg_data",  dbg_data,      m_r[dbg_addr]);
  end

  task automatic issue(input logic [3:0] op, input logic [2:0] rd, rs, rt,
                       input logic [7:0] s, j);
    int n;
    @(negedge clk);
    n = 0;
    while (cif.cmd_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    if (n >= 8) begin
      total++; bad++;
      $display("FAIL ready_timeout: cmd_ready=%b want 1", cif.cmd_ready);
    end
    cif.cmd_valid = 1'b1;
    cif.cmd_op = op; cif.cmd_rd = rd; cif.cmd_rs = rs; cif.cmd_rt = rt;
    seed = s; junk = j;
    @(posedge clk);
    @(negedge clk);
    // Fields are don't-care after the accept edge.
    cif.cmd_valid = 1'b0;
    cif.cmd_op = 4'($urandom); cif.cmd_rd = 3'($urandom);
    cif.cmd_rs = 3'($urandom); cif.cmd_rt = 3'($urandom);
    n = 1;
    while (done !== 1'b1 && n < 8) begin @(negedge clk); n++; end
    chk("done_latency", n, 2);
    @(negedge clk);
  endtask

  initial begin
    cif.cmd_valid = 1'b0; cif.cmd_op = '0;
    cif.cmd_rd = '0; cif.cmd_rs = '0; cif.cmd_rt = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("reset_ready", cif.cmd_ready, 1);
    chk("reset_car", car_q, 8'h00);

    // ADD with carry out of the top bit
    issue(4'd6, 3'd1, 3'd0, 3'd0, 8'hF0, 8'h00);
    issue(4'd6, 3'd2, 3'd0, 3'd0, 8'h20, 8'h00);
    issue(4'd4, 3'd3, 3'd1, 3'd2, 8'h00, 8'h77);
    chk("pin_add_r3", m_r[3], 8'h10);
    chk("pin_add_car", m_car, 8'h01);
    chk("pin_add_zero", m_zero, 1'b0);

    // SLL spills into car; following AND must not touch car_q
    issue(4'd6, 3'd5, 3'd0, 3'd0, 8'h81, 8'h00);
    issue(4'd6, 3'd6, 3'd0, 3'd0, 8'h01, 8'h00);
    issue(4'd8, 3'd4, 3'd5, 3'd6, 8'h00, 8'h3C);
    chk("pin_sll_r4", m_r[4], 8'h02);
    chk("pin_sll_car", m_car, 8'h01);
    issue(4'd0, 3'd7, 3'd1, 3'd2, 8'h00, 8'hAA);
    chk("pin_and_car", m_car, 8'h01);
    chk("pin_and_r7", m_r[7], 8'h20);

    // BEQ taken / not taken, no register write
    issue(4'd7, 3'd3, 3'd1, 3'd1, 8'h00, 8'h11);
    chk("pin_beq_taken", m_taken, 1'b1);
    chk("pin_beq_r3", m_r[3], 8'h10);
    issue(4'd7, 3'd3, 3'd1, 3'd2, 8'h00, 8'h11);
    chk("pin_bne_taken", m_taken, 1'b0);

    // Write to R0 discarded, zero flag from result
    issue(4'd6, 3'd5, 3'd0, 3'd0, 8'h05, 8'h00);
    issue(4'd6, 3'd6, 3'd0, 3'd0, 8'h03, 8'h00);
    issue(4'd4, 3'd0, 3'd5, 3'd6, 8'h00, 8'h99);
    chk("pin_r0", m_r[0], 8'h00);
    chk("pin_r0_zero", m_zero, 1'b0);
    chk("pin_r0_car", m_car, 8'h00);
    issue(4'd5, 3'd7, 3'd5, 3'd5, 8'h00, 8'h42);
    chk("pin_sub_zero", m_zero, 1'b1);
    chk("pin_sub_r7", m_r[7], 8'h00);

    // Illegal op: err_q sticky only when the feature is built in
    issue(4'd12, 3'd2, 3'd1, 3'd2, 8'h00, 8'h13);
    chk("pin_err", m_err, ERR_EN);
    chk("err_q_op12", err_q, ERR_EN);
    chk("pin_ill_r2", m_r[2], 8'h20);
    issue(4'd0, 3'd3, 3'd1, 3'd1, 8'h00, 8'h00);
    chk("err_q_sticky", err_q, ERR_EN);

    // Reset during EXEC aborts the command
    @(negedge clk);
    cif.cmd_valid = 1'b1; cif.cmd_op = 4'd4;
    cif.cmd_rd = 3'd3; cif.cmd_rs = 3'd1; cif.cmd_rt = 3'd1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    cif.cmd_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("rst_abort_done", done, 1'b0);
    chk("rst_abort_err", err_q, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    chk("rst_abort_r3", dbg_data, m_r[dbg_addr]);
    chk("pin_rst_r3", m_r[3], 8'h00);

    // Randomized traffic, valid also toggling while busy
    repeat (600) begin
      @(negedge clk);
      cif.cmd_valid = ($urandom_range(0, 99) < 60);
      cif.cmd_op = ($urandom_range(0, 3) == 0) ? 4'd6 : 4'($urandom);
      cif.cmd_rd = 3'($urandom); cif.cmd_rs = 3'($urandom); cif.cmd_rt = 3'($urandom);
      seed = 8'($urandom); junk = 8'($urandom);
    end
    @(negedge clk);
    cif.cmd_valid = 1'b0;
    repeat (6) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
